sram_ctrl_arb: RTL
==================

Name: sram_ctrl_arb

Overview:
- Synchronous controller that shares one asynchronous 8k x 8 SRAM (MCM6264C) between two requesters, A and B.
- Arbitrates round-robin between the two ports.
- Sequences chip-enable (e1 low / e2 high), write-enable w and output-enable g with programmable pulse widths.
- Returns read data with a one-cycle ack pulse per transaction.
- Sits between the system-side masters and the SRAM instance.

Parameters:
- ADDR_W, 13, SRAM address width.
- DATA_W, 8, SRAM word width.
- WR_PULSE, 2, clock cycles w is held low; must be >= 1.
- RD_WAIT, 2, clock cycles g is held low before data capture; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_a / req_b  in  1  transaction request; held high until ack.
- we_a / we_b  in  1  1 = write, 0 = read; stable while req is high.
- addr_a / addr_b  in  ADDR_W  word address; stable while req is high.
- wdata_a / wdata_b  in  DATA_W  write data; stable while req is high.
- ack_a / ack_b  out  1  one-cycle completion pulse.
- rdata_a / rdata_b  out  DATA_W  read data; valid in the ack cycle and held until that port's next read completes.
- busy  out  1  high in every state other than IDLE.
- sram_addr  out  ADDR_W  to SRAM address.
- sram_din  out  DATA_W  to SRAM datain.
- sram_dout  in  DATA_W  from SRAM dataout.
- sram_e1  out  1  chip enable, active-low.
- sram_e2  out  1  chip enable, active-high.
- sram_w  out  1  write enable, active-low.
- sram_g  out  1  output enable, active-low.

Behaviour:
- All outputs are registered.
- Reset values:
  - sram_e1=1, sram_e2=0, sram_w=1, sram_g=1.
  - sram_addr=0, sram_din=0.
  - ack_a/ack_b=0, rdata_a/rdata_b=0, busy=0.
  - state=IDLE; round-robin pointer favours A.
- States: IDLE, SETUP, WPULSE, WREC, RPULSE, RDONE.
- IDLE:
  - Chip deselected.
  - If exactly one req is high, grant that port.
  - If both are high, grant the port not granted last.
  - On grant: latch the port id, latch we, load sram_addr/sram_din from that port, and go to SETUP.
- SETUP (1 cycle): e1=0, e2=1, w=1, g=1. The address is stable before any strobe. Then go to WPULSE if we=1, otherwise RPULSE.
- WPULSE (WR_PULSE cycles): w=0, g=1; a down-counter is loaded on entry. When the counter expires, go to WREC.
- WREC (1 cycle):
  - w=1 and the chip stays enabled, so data and address are held past the rising edge of w.
  - The granted ack is high this cycle. Then go to IDLE.
- RPULSE (RD_WAIT cycles): g=0, w=1. On the last cycle, sram_dout is captured into the granted port's rdata; then go to RDONE.
- RDONE (1 cycle): g=1; ack is high and rdata is valid. Then go to IDLE.
- Latency, counted from the IDLE cycle in which req is sampled:
  - write ack is WR_PULSE+2 cycles later;
  - read ack is RD_WAIT+2 cycles later.
  - Minimum spacing between grants is WR_PULSE+3 (write) or RD_WAIT+3 (read) cycles.
- w and g are never low in the same cycle.
- e1 and e2 only change in IDLE → SETUP and WREC/RDONE → IDLE.
- Requester rule: drop req, or present a new transaction, in the cycle after ack. req is only sampled in IDLE, so there is no double issue.
- The round-robin pointer updates on grant, not on ack.
- The non-granted port's request waits. Its ack and rdata are unaffected.
- A request arriving mid-transaction is served at the next IDLE.
- Address 2^ADDR_W-1 is valid; there is no wrap logic.
- Reset mid-operation:
  - Outputs return to reset values immediately (asynchronously).
  - The in-flight write may be incomplete and is not acked.
  - rdata values are cleared.
- Requests with we toggling while req is high are illegal. The bench asserts against this.

Decomposition:
- Package sram_ctrl_pkg holds:
  - state enum (IDLE, SETUP, WPULSE, WREC, RPULSE, RDONE);
  - port-id constants PORT_A=0, PORT_B=1;
  - strobe idle-level constants.
- One sub-module, rr_arb2: two-request round-robin arbiter with grant-enable input and registered last-grant pointer.

Test Plan:
- Reset check: with rst_n=0 → e1=1, e2=0, w=1, g=1, acks 0, busy 0. Release reset, no requests → stays IDLE.
- Single write: A writes 8'h5A to 13'h0064 → w low exactly 2 cycles while e1=0, e2=1, addr=0x0064, din=0x5A; ack_a 4 cycles after req is sampled. A then reads 0x0064 → g low 2 cycles, rdata_a=0x5A with ack_a 4 cycles after sampling.
- Simultaneous requests: A and B both request writes (A: 0x0001←0x11, B: 0x0002←0x22) in the same cycle → A served first after reset, then B. Two back-to-back dual requests → grants alternate A, B, A, B.
- Boundary addresses: write/read at 13'h0000 and 13'h1FFF with data 8'hFF and 8'h00 → correct readback; ack_b never fires for A's transactions.
- Reset mid-WPULSE: assert rst_n=0 → w and e1 high immediately, no ack, state IDLE. A subsequent read still operates normally.
- Parameter sweep: WR_PULSE=1, RD_WAIT=5 → w-low width 1 cycle, g-low width 5 cycles, read ack latency 7 cycles.

Source files
------------

// File: rtl/sram_ctrl_arb_pkg.sv
// Shared types and constants for the two-port SRAM controller.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WPULSE,
        WREC,
        RPULSE,
        RDONE
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Deasserted levels of the SRAM control strobes
    localparam logic E1_OFF = 1'b1;
    localparam logic E2_OFF = 1'b0;
    localparam logic W_OFF  = 1'b1;
    localparam logic G_OFF  = 1'b1;

    localparam int CNT_W = 8;

endpackage

// File: rtl/sram_ctrl_arb_rr_arb2.sv
// Two-request round-robin arbiter; the last-grant pointer moves only when en is high.
module rr_arb2
    import sram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic en,
    output logic gnt_valid,
    output logic gnt_id
);

    logic last_reg;

    always_comb begin
        gnt_valid = req_a | req_b;
        if (req_a && req_b) begin
            gnt_id = (last_reg == PORT_A) ? PORT_B : PORT_A;
        end else if (req_a) begin
            gnt_id = PORT_A;
        end else begin
            gnt_id = PORT_B;
        end
    end

    // Starting as "B was last" makes A win the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= PORT_B;
        end else if (en && gnt_valid) begin
            last_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/sram_ctrl_arb.sv
// Shares one asynchronous SRAM between two requesters with round-robin arbitration
// and programmable write / output-enable pulse widths. All outputs are registered.
module sram_ctrl_arb
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 8,
    parameter int WR_PULSE = 2,
    parameter int RD_WAIT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_a,
    output logic              ack_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    input  logic [DATA_W-1:0] sram_dout,
    output logic              sram_e1,
    output logic              sram_e2,
    output logic              sram_w,
    output logic              sram_g
);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              port_reg, port_next;
    logic              we_reg, we_next;
    logic              gnt_valid, gnt_id;

    logic              e1_reg, e1_next, e2_reg, e2_next;
    logic              w_reg, w_next, g_reg, g_next;
    logic              ack_a_reg, ack_a_next, ack_b_reg, ack_b_next;
    logic              busy_reg, busy_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] din_reg, din_next;
    logic [DATA_W-1:0] rdata_a_reg, rdata_a_next, rdata_b_reg, rdata_b_next;
    logic              capture;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .req_b     (req_b),
        .en        (state_reg == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            port_reg    <= PORT_A;
            we_reg      <= 1'b0;
            e1_reg      <= E1_OFF;
            e2_reg      <= E2_OFF;
            w_reg       <= W_OFF;
            g_reg       <= G_OFF;
            ack_a_reg   <= 1'b0;
            ack_b_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            addr_reg    <= '0;
            din_reg     <= '0;
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            port_reg    <= port_next;
            we_reg      <= we_next;
            e1_reg      <= e1_next;
            e2_reg      <= e2_next;
            w_reg       <= w_next;
            g_reg       <= g_next;
            ack_a_reg   <= ack_a_next;
            ack_b_reg   <= ack_b_next;
            busy_reg    <= busy_next;
            addr_reg    <= addr_next;
            din_reg     <= din_next;
            rdata_a_reg <= rdata_a_next;
            rdata_b_reg <= rdata_b_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        port_next  = port_reg;
        we_next    = we_reg;
        case (state_reg)
            IDLE: begin
                if (gnt_valid) begin
                    state_next = SETUP;
                    port_next  = gnt_id;
                    we_next    = (gnt_id == PORT_A) ? we_a : we_b;
                end
            end
            SETUP: begin
                if (we_reg) begin
                    state_next = WPULSE;
                    cnt_next   = CNT_W'(WR_PULSE - 1);
                end else begin
                    state_next = RPULSE;
                    cnt_next   = CNT_W'(RD_WAIT - 1);
                end
            end
            WPULSE: begin
                if (cnt_reg == '0) state_next = WREC;
                else               cnt_next   = cnt_reg - CNT_W'(1);
            end
            WREC:   state_next = IDLE;
            RPULSE: begin
                if (cnt_reg == '0) state_next = RDONE;
                else               cnt_next   = cnt_reg - CNT_W'(1);
            end
            RDONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded from the state being entered so they are registered with it
    always_comb begin
        e1_next    = (state_next == IDLE) ? E1_OFF : ~E1_OFF;
        e2_next    = (state_next == IDLE) ? E2_OFF : ~E2_OFF;
        w_next     = (state_next == WPULSE) ? ~W_OFF : W_OFF;
        g_next     = (state_next == RPULSE) ? ~G_OFF : G_OFF;
        busy_next  = (state_next != IDLE);
        ack_a_next = ((state_next == WREC) || (state_next == RDONE)) && (port_next == PORT_A);
        ack_b_next = ((state_next == WREC) || (state_next == RDONE)) && (port_next == PORT_B);
        addr_next  = addr_reg;
        din_next   = din_reg;
        if (state_reg == IDLE && gnt_valid) begin
            addr_next = (gnt_id == PORT_A) ? addr_a  : addr_b;
            din_next  = (gnt_id == PORT_A) ? wdata_a : wdata_b;
        end
        capture      = (state_reg == RPULSE) && (cnt_reg == '0);
        rdata_a_next = (capture && port_reg == PORT_A) ? sram_dout : rdata_a_reg;
        rdata_b_next = (capture && port_reg == PORT_B) ? sram_dout : rdata_b_reg;
    end

    assign ack_a     = ack_a_reg;
    assign ack_b     = ack_b_reg;
    assign rdata_a   = rdata_a_reg;
    assign rdata_b   = rdata_b_reg;
    assign busy      = busy_reg;
    assign sram_addr = addr_reg;
    assign sram_din  = din_reg;
    assign sram_e1   = e1_reg;
    assign sram_e2   = e2_reg;
    assign sram_w    = w_reg;
    assign sram_g    = g_reg;

endmodule
